// File: rtl/fir_out_requant.sv
// fir_out_requant: decimate, round/shift/saturate FIR samples, and buffer them in a valid/ready FIFO with diagnostics.
module fir_out_requant #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_data,
  input  logic [7:0]                    decim_ratio,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_sat,
  output logic [15:0]                   sat_count,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int QW = IN_W - SHIFT + 1;
  localparam logic signed [QW-1:0] QMAX = QW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [QW-1:0] QMIN = ~QMAX;
  localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(1) << (SHIFT - 1);
  logic [7:0] ratio, phase_q, phase_d, r_q, r_d;
  logic keep, wrap;
  logic signed [IN_W:0] t;
  logic signed [QW-1:0] q;
  logic [OUT_W-1:0] res, st_data_q, st_data_d;
  logic res_sat, st_v_q, st_v_d, st_sat_q, st_sat_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic [15:0] sat_q, sat_d, drop_q, drop_d;
  logic [OUT_W:0] mem_q [FIFO_DEPTH];
  logic full, pop, push;
  always_comb begin
    ratio     = (decim_ratio == 8'd0) ? 8'd1 : decim_ratio;
    keep      = in_valid && phase_q == 8'd0;
    wrap      = in_valid && phase_q == r_q - 8'd1;
    phase_d   = wrap ? 8'd0 : in_valid ? phase_q + 8'd1 : phase_q;
    r_d       = wrap ? ratio : r_q;
    // extra MSB keeps the rounding add from wrapping near +full-scale
    t         = $signed({in_data[IN_W-1], in_data}) + HALF;
    q         = t[IN_W:SHIFT];
    res_sat   = (q > QMAX) || (q < QMIN);
    res       = (q > QMAX) ? {1'b0, {(OUT_W-1){1'b1}}} :
                (q < QMIN) ? {1'b1, {(OUT_W-1){1'b0}}} : q[OUT_W-1:0];
    st_v_d    = keep;
    st_data_d = keep ? res : st_data_q;
    st_sat_d  = keep ? res_sat : st_sat_q;
    full      = level_q == (AW + 1)'(FIFO_DEPTH);
    out_valid = level_q != '0;
    pop       = out_valid && out_ready;
    push      = st_v_q && (!full || pop);
    wr_d      = push ? wr_q + 1'b1 : wr_q;
    rd_d      = pop ? rd_q + 1'b1 : rd_q;
    level_d   = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    sat_d     = (push && st_sat_q && sat_q != 16'hFFFF) ? sat_q + 16'd1 : sat_q;
    drop_d    = (st_v_q && !push && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    out_data  = out_valid ? mem_q[rd_q][OUT_W-1:0] : '0;
    out_sat   = out_valid && mem_q[rd_q][OUT_W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= 8'd0;
      r_q       <= ratio;
      st_v_q    <= 1'b0;
      st_data_q <= '0;
      st_sat_q  <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      sat_q     <= 16'd0;
      drop_q    <= 16'd0;
    end else begin
      phase_q   <= phase_d;
      r_q       <= r_d;
      st_v_q    <= st_v_d;
      st_data_q <= st_data_d;
      st_sat_q  <= st_sat_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      level_q   <= level_d;
      sat_q     <= sat_d;
      drop_q    <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {st_sat_q, st_data_q};
  end
  assign sat_count  = sat_q;
  assign drop_count = drop_q;
  assign fifo_level = level_q;
endmodule
